// File: rtl/wb_mem_stage.sv
// Stage 3 (memory/writeback) of the RV32I pipeline: data-memory access, load alignment, register-file write.
// Optional macro WB_FORWARD_EN adds same-cycle forwarding outputs fwd_valid/fwd_rd/fwd_data.
module wb_mem_stage #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_we,
  input  logic [1:0]        in_wb_sel,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_alu_res,
  input  logic [XLEN-1:0]   in_pc4,
  input  logic [XLEN-1:0]   in_store_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wmask,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [4:0]        rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              we,
  output logic              stall
`ifdef WB_FORWARD_EN
  ,
  output logic              fwd_valid,
  output logic [4:0]        fwd_rd,
  output logic [XLEN-1:0]   fwd_data
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  state_t            state_q, state_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              we_q, we_d;
  logic [4:0]        st_rd_q, st_rd_d;
  logic              st_we_q, st_we_d;
  logic              st_load_q, st_load_d;
  logic [2:0]        st_f3_q, st_f3_d;
  logic [1:0]        st_off_q, st_off_d;
  logic              accept;
  logic              in_mem;

  assign accept = in_valid && (state_q == S_IDLE);
  assign in_mem = in_is_load || in_is_store;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_wmask_q     <= 4'b0000;
      mem_wdata_q     <= '0;
      rd_q            <= 5'd0;
      wb_data_q       <= '0;
      we_q            <= 1'b0;
      st_rd_q         <= 5'd0;
      st_we_q         <= 1'b0;
      st_load_q       <= 1'b0;
      st_f3_q         <= 3'd0;
      st_off_q        <= 2'd0;
    end else begin
      state_q         <= state_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      mem_wmask_q     <= mem_wmask_d;
      mem_wdata_q     <= mem_wdata_d;
      rd_q            <= rd_d;
      wb_data_q       <= wb_data_d;
      we_q            <= we_d;
      st_rd_q         <= st_rd_d;
      st_we_q         <= st_we_d;
      st_load_q       <= st_load_d;
      st_f3_q         <= st_f3_d;
      st_off_q        <= st_off_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && in_mem) state_d = S_REQ;
        else                  state_d = S_IDLE;
      end
      S_REQ: begin
        if (mem_req_ready) state_d = st_load_q ? S_WAIT : S_IDLE;
        else               state_d = S_REQ;
      end
      S_WAIT: begin
        if (mem_resp_valid) state_d = S_IDLE;
        else                state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request fields are only loaded on acceptance, so they stay stable for the whole REQ phase.
  always_comb begin
    mem_req_valid_d = mem_req_valid_q;
    mem_addr_d      = mem_addr_q;
    mem_wmask_d     = mem_wmask_q;
    mem_wdata_d     = mem_wdata_q;
    rd_d            = rd_q;
    wb_data_d       = wb_data_q;
    we_d            = 1'b0;
    st_rd_d         = st_rd_q;
    st_we_d         = st_we_q;
    st_load_d       = st_load_q;
    st_f3_d         = st_f3_q;
    st_off_d        = st_off_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          st_rd_d   = in_rd;
          st_we_d   = in_reg_we;
          st_load_d = in_is_load;
          st_f3_d   = in_funct3;
          st_off_d  = in_alu_res[1:0];
          if (in_mem) begin
            mem_req_valid_d = 1'b1;
            mem_addr_d      = {in_alu_res[ADDR_W-1:2], 2'b00};
            mem_wmask_d     = in_is_load ? 4'b0000 : store_mask(in_funct3, in_alu_res[1:0]);
            mem_wdata_d     = store_lanes(in_funct3, in_store_data);
          end else begin
            we_d = in_reg_we && (in_rd != 5'd0);
            rd_d = in_rd;
            case (in_wb_sel)
              2'd2:    wb_data_d = in_pc4;
              2'd1:    wb_data_d = mem_rdata;
              default: wb_data_d = in_alu_res;
            endcase
          end
        end else begin
          we_d = 1'b0;
        end
      end
      S_REQ: begin
        if (mem_req_ready) mem_req_valid_d = 1'b0;
        else               mem_req_valid_d = 1'b1;
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          we_d      = st_we_q && (st_rd_q != 5'd0);
          rd_d      = st_rd_q;
          wb_data_d = load_align(st_f3_q, st_off_q, mem_rdata);
        end else begin
          we_d = 1'b0;
        end
      end
      default: we_d = 1'b0;
    endcase
  end

  assign stall         = (state_q != S_IDLE);
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wmask     = mem_wmask_q;
  assign mem_wdata     = mem_wdata_q;
  assign rd            = rd_q;
  assign wb_data       = wb_data_q;
  assign we            = we_q;

`ifdef WB_FORWARD_EN
  assign fwd_valid = we_q;
  assign fwd_rd    = rd_q;
  assign fwd_data  = wb_data_q;
`endif

endmodule

// File: tb/tb_wb_mem_stage.sv
// Scoreboard bench for wb_mem_stage: expected writebacks are queued at issue and checked on each we pulse.
module tb_wb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [4:0]  in_rd;
  logic        in_reg_we;
  logic [1:0]  in_wb_sel;
  logic        in_is_load;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_res;
  logic [31:0] in_pc4;
  logic [31:0] in_store_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic [4:0]  rd;
  logic [31:0] wb_data;
  logic        we;
  logic        stall;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  always #5 clk = ~clk;

  wb_mem_stage #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_rd(in_rd), .in_reg_we(in_reg_we),
    .in_wb_sel(in_wb_sel), .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_alu_res(in_alu_res), .in_pc4(in_pc4),
    .in_store_data(in_store_data), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .rd(rd), .wb_data(wb_data), .we(we), .stall(stall)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every we pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_we", {27'd0, rd}, 32'hFFFF_FFFF);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        check_eq("wb_rd", {27'd0, rd}, {27'd0, e.rd});
        check_eq("wb_data", wb_data, e.data);
      end
    end
  end

  task automatic drive(input logic [4:0] rd_i, input logic reg_we_i, input logic [1:0] sel,
                       input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] sd);
    in_valid = 1'b1; in_rd = rd_i; in_reg_we = reg_we_i; in_wb_sel = sel;
    in_is_load = ld; in_is_store = st; in_funct3 = f3;
    in_alu_res = alu; in_pc4 = pc4; in_store_data = sd;
    @(posedge clk); #1;
    in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    wb_t e;
    e.rd = r; e.data = d;
    exp_q.push_back(e);
  endtask

  // Holds ready low (with stray responses) then completes the handshake and, for loads, the response.
  task automatic mem_cycle(input int ready_dly, input bit is_ld, input int resp_dly,
                           input logic [31:0] rdata);
    for (int i = 0; i < ready_dly; i++) begin
      check_eq("req_hold_valid", {31'd0, mem_req_valid}, 32'd1);
      check_eq("req_hold_stall", {31'd0, stall}, 32'd1);
      mem_resp_valid = 1'b1;
      mem_rdata = 32'h5A5A_5A5A;
      @(posedge clk); #1;
    end
    mem_resp_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    if (is_ld) begin
      check_eq("wait_req_drop", {31'd0, mem_req_valid}, 32'd0);
      check_eq("wait_stall", {31'd0, stall}, 32'd1);
      for (int i = 0; i < resp_dly; i++) begin
        @(posedge clk); #1;
      end
      mem_resp_valid = 1'b1;
      mem_rdata = rdata;
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      mem_rdata = 32'h5A5A_5A5A;
    end
    check_eq("done_stall", {31'd0, stall}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_rd = 5'd0; in_reg_we = 1'b0; in_wb_sel = 2'd0;
    in_is_load = 1'b0; in_is_store = 1'b0; in_funct3 = 3'd0; in_alu_res = 32'd0;
    in_pc4 = 32'd0; in_store_data = 32'd0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_eq("rst_we", {31'd0, we}, 32'd0);
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check_eq("rst_wb_data", wb_data, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);

    // Back-to-back non-memory ops: ALU, JAL, x0 write, reserved select.
    push(5'd5, 32'h0000_1234);
    drive(5'd5, 1'b1, 2'd0, 1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0000_0050, 32'd0);
    check_eq("alu_we_next_cycle", {31'd0, we}, 32'd1);
    check_eq("alu_stall", {31'd0, stall}, 32'd0);
    push(5'd1, 32'h0000_0104);
    drive(5'd1, 1'b1, 2'd2, 1'b0, 1'b0, 3'd0, 32'h0000_0FFF, 32'h0000_0104, 32'd0);
    check_eq("jal_we_consecutive", {31'd0, we}, 32'd1);
    drive(5'd0, 1'b1, 2'd0, 1'b0, 1'b0, 3'd0, 32'h0000_9999, 32'd0, 32'd0);
    check_eq("x0_we", {31'd0, we}, 32'd0);
    push(5'd7, 32'h0000_0077);
    drive(5'd7, 1'b1, 2'd3, 1'b0, 1'b0, 3'd0, 32'h0000_0077, 32'h0000_0200, 32'd0);
    @(posedge clk); #1;

    // LB from 0x1003.
    push(5'd2, 32'hFFFF_FF80);
    drive(5'd2, 1'b1, 2'd1, 1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'd0);
    check_eq("lb_addr", mem_addr, 32'h0000_1000);
    check_eq("lb_wmask", {28'd0, mem_wmask}, 32'd0);
    check_eq("lb_stall", {31'd0, stall}, 32'd1);
    mem_cycle(2, 1'b1, 2, 32'h80FF_FFFF);
    check_eq("lb_addr_stable", mem_addr, 32'h0000_1000);

    push(5'd3, 32'h0000_BEEF);
    drive(5'd3, 1'b1, 2'd1, 1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'd0, 32'd0);
    check_eq("lhu_addr", mem_addr, 32'h0000_2000);
    mem_cycle(1, 1'b1, 0, 32'hBEEF_0000);
    push(5'd4, 32'hDEAD_BEEF);
    drive(5'd4, 1'b1, 2'd1, 1'b1, 1'b0, 3'b010, 32'h0000_2004, 32'd0, 32'd0);
    mem_cycle(1, 1'b1, 1, 32'hDEAD_BEEF);
    push(5'd6, 32'hFFFF_8001);
    drive(5'd6, 1'b1, 2'd1, 1'b1, 1'b0, 3'b001, 32'h0000_2000, 32'd0, 32'd0);
    mem_cycle(1, 1'b1, 0, 32'h1234_8001);
    push(5'd8, 32'h0000_009A);
    drive(5'd8, 1'b1, 2'd1, 1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'd0, 32'd0);
    mem_cycle(1, 1'b1, 0, 32'h0000_9A00);

    // Stores: reg_we set on purpose; we must still stay low.
    drive(5'd9, 1'b1, 2'd0, 1'b0, 1'b1, 3'b000, 32'h0000_3001, 32'd0, 32'h1234_56AB);
    check_eq("sb_addr", mem_addr, 32'h0000_3000);
    check_eq("sb_wmask", {28'd0, mem_wmask}, 32'h0000_0002);
    check_eq("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    mem_cycle(1, 1'b0, 0, 32'd0);
    drive(5'd9, 1'b1, 2'd0, 1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'd0, 32'h0000_CAFE);
    check_eq("sh_wmask", {28'd0, mem_wmask}, 32'h0000_000C);
    check_eq("sh_wdata", mem_wdata, 32'hCAFE_CAFE);
    mem_cycle(2, 1'b0, 0, 32'd0);
    drive(5'd9, 1'b1, 2'd0, 1'b0, 1'b1, 3'b010, 32'h0000_3004, 32'd0, 32'h1122_3344);
    check_eq("sw_wmask", {28'd0, mem_wmask}, 32'h0000_000F);
    check_eq("sw_wdata", mem_wdata, 32'h1122_3344);
    mem_cycle(1, 1'b0, 0, 32'd0);

    // Reset while waiting for load data; the late response must be ignored.
    drive(5'd3, 1'b1, 2'd1, 1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'd0, 32'd0);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    check_eq("pre_rst_wait_stall", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("rst_wait_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_wait_req", {31'd0, mem_req_valid}, 32'd0);
    mem_resp_valid = 1'b1; mem_rdata = 32'hCCCC_CCCC;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    check_eq("stale_resp_we", {31'd0, we}, 32'd0);
    check_eq("stale_resp_stall", {31'd0, stall}, 32'd0);

    // Reset during REQ drops the request.
    drive(5'd3, 1'b1, 2'd1, 1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'd0, 32'd0);
    check_eq("req_before_rst", {31'd0, mem_req_valid}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("rst_req_drop", {31'd0, mem_req_valid}, 32'd0);
    check_eq("rst_req_stall", {31'd0, stall}, 32'd0);

    push(5'd10, 32'h0000_A5A5);
    drive(5'd10, 1'b1, 2'd0, 1'b0, 1'b0, 3'd0, 32'h0000_A5A5, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
